vga_frame_monitor: RTL and testbench

VGA_FRAME_MONITOR -- requirements
Module: vga_frame_monitor

---
 rtl/vga_frame_monitor.sv | 167 ++++++++++++++++
 tb/tb_vga_frame_monitor.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_monitor.sv
// Measures line length, lines per frame and lit-pixel statistics of a captured
// VGA stream, and exposes them through a small memory-mapped register bank.
module vga_frame_monitor (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  vga_in,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, RUN = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [7:0]  ctrl_q, ctrl_d;
  logic [1:0]  status_q, status_d;
  logic [15:0] htotal_q, htotal_d;
  logic [11:0] vtotal_q, vtotal_d;
  logic [19:0] lit_q, lit_d;
  logic [23:0] sum_q, sum_d;
  logic [7:0]  frames_q, frames_d;
  logic [15:0] clk_cnt_q, clk_cnt_d;
  logic [11:0] line_cnt_q, line_cnt_d;
  logic [19:0] lit_cnt_q, lit_cnt_d;
  logic [23:0] sum_acc_q, sum_acc_d;
  logic        vs_prev_q, vs_prev_d;
  logic        hs_prev_q, hs_prev_d;

  logic        wr_s, vs_act_s, hs_act_s, v_edge_s, h_edge_s, pix_lit_s, running_s;
  logic        frame_set_s, sat_set_s;
  logic [1:0]  status_keep_s;
  logic [15:0] clk_inc_s;
  logic        unused_s;

  assign unused_s  = ^{data_read_n, data_in[31:8]};
  assign wr_s      = (data_write_n != 2'b11);
  // A sync is active when its level matches the programmed polarity.
  assign vs_act_s  = (vga_in[7] == ctrl_q[1]);
  assign hs_act_s  = (vga_in[6] == ctrl_q[1]);
  assign v_edge_s  = vs_act_s & (vs_prev_q != ctrl_q[1]);
  assign h_edge_s  = hs_act_s & (hs_prev_q != ctrl_q[1]);
  assign pix_lit_s = ~vs_act_s & ~hs_act_s & (vga_in[5:0] != 6'd0);
  assign running_s = (state_q == RUN);
  assign clk_inc_s = (clk_cnt_q == 16'hFFFF) ? 16'hFFFF : (clk_cnt_q + 16'd1);
  assign frame_set_s   = running_s & v_edge_s;
  assign status_keep_s = (wr_s && (address == 6'h04)) ? 2'b00 : status_q;

  // Next-state logic for the capture FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ctrl_q[0]) state_d = ARM;
        else           state_d = IDLE;
      end
      ARM: begin
        if (!ctrl_q[0])    state_d = IDLE;
        else if (v_edge_s) state_d = RUN;
        else               state_d = ARM;
      end
      RUN: begin
        if (!ctrl_q[0]) state_d = IDLE;
        else            state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Register-bank updates, frame latching and working counters.
  always_comb begin
    vs_prev_d = vga_in[7];
    hs_prev_d = vga_in[6];
    if (wr_s && (address == 6'h00)) ctrl_d = data_in[7:0];
    else                            ctrl_d = ctrl_q;
    if (running_s && h_edge_s) htotal_d = clk_inc_s;
    else                       htotal_d = htotal_q;
    if (frame_set_s) begin
      vtotal_d = line_cnt_q + {11'd0, h_edge_s};
      lit_d    = lit_cnt_q;
      sum_d    = sum_acc_q;
      frames_d = frames_q + 8'd1;
    end else begin
      vtotal_d = vtotal_q;
      lit_d    = lit_q;
      sum_d    = sum_q;
      frames_d = frames_q;
    end
    // Counters only live while RUN persists; entering or leaving RUN zeroes them.
    if (!running_s || (state_d != RUN)) begin
      clk_cnt_d  = 16'd0;
      line_cnt_d = 12'd0;
      lit_cnt_d  = 20'd0;
      sum_acc_d  = 24'd0;
    end else begin
      clk_cnt_d = h_edge_s ? 16'd0 : clk_inc_s;
      if (v_edge_s) begin
        line_cnt_d = 12'd0;
        lit_cnt_d  = 20'd0;
        sum_acc_d  = 24'd0;
      end else begin
        line_cnt_d = h_edge_s ? (line_cnt_q + 12'd1) : line_cnt_q;
        lit_cnt_d  = pix_lit_s ? (lit_cnt_q + 20'd1) : lit_cnt_q;
        sum_acc_d  = pix_lit_s ? (sum_acc_q + {18'd0, vga_in[5:0]}) : sum_acc_q;
      end
    end
    sat_set_s = (clk_cnt_d == 16'hFFFF);
    status_d  = status_keep_s | {sat_set_s, frame_set_s};
  end

  // Combinational read mux.
  always_comb begin
    data_out = 32'd0;
    case (address)
      6'h00:   data_out = {24'd0, ctrl_q};
      6'h04:   data_out = {30'd0, status_q};
      6'h08:   data_out = {16'd0, htotal_q};
      6'h0C:   data_out = {20'd0, vtotal_q};
      6'h10:   data_out = {12'd0, lit_q};
      6'h14:   data_out = {8'd0, sum_q};
      6'h18:   data_out = {24'd0, frames_q};
      default: data_out = 32'd0;
    endcase
  end

  assign data_ready     = 1'b1;
  assign user_interrupt = status_q[0] & ctrl_q[2];

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ctrl_q     <= 8'd0;
      status_q   <= 2'd0;
      htotal_q   <= 16'd0;
      vtotal_q   <= 12'd0;
      lit_q      <= 20'd0;
      sum_q      <= 24'd0;
      frames_q   <= 8'd0;
      clk_cnt_q  <= 16'd0;
      line_cnt_q <= 12'd0;
      lit_cnt_q  <= 20'd0;
      sum_acc_q  <= 24'd0;
      vs_prev_q  <= 1'b0;
      hs_prev_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      status_q   <= status_d;
      htotal_q   <= htotal_d;
      vtotal_q   <= vtotal_d;
      lit_q      <= lit_d;
      sum_q      <= sum_d;
      frames_q   <= frames_d;
      clk_cnt_q  <= clk_cnt_d;
      line_cnt_q <= line_cnt_d;
      lit_cnt_q  <= lit_cnt_d;
      sum_acc_q  <= sum_acc_d;
      vs_prev_q  <= vs_prev_d;
      hs_prev_q  <= hs_prev_d;
    end
  end

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Directed bench for vga_frame_monitor: synthetic 100-clock lines, 10-line
// frames, register reads compared against hand-computed values.
module tb_vga_frame_monitor;

  logic        clk;
  logic        rst_n;
  logic [7:0]  vga_in;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;

  int n_checks = 0;
  int n_fail   = 0;

  vga_frame_monitor dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .vga_in         (vga_in),
    .address        (address),
    .data_in        (data_in),
    .data_write_n   (data_write_n),
    .data_read_n    (data_read_n),
    .data_out       (data_out),
    .data_ready     (data_ready),
    .user_interrupt (user_interrupt)
  );

  initial clk = 1'b0;
  always #8 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = data_out;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] v, input logic [1:0] strobe);
    address      = a;
    data_in      = v;
    data_write_n = strobe;
    tick();
    data_write_n = 2'b11;
  endtask

  task automatic idle(input int n, input bit pol);
    vga_in = {~pol, ~pol, 6'h00};
    repeat (n) tick();
  endtask

  task automatic hpulse(input bit pol);
    vga_in = {~pol, pol, 6'h00};
    tick();
  endtask

  task automatic vpulse(input bit pol);
    vga_in = {pol, ~pol, 6'h00};
    tick();
  endtask

  task automatic do_reset(input bit pol);
    rst_n  = 1'b0;
    vga_in = {~pol, ~pol, 6'h00};
    repeat (2) tick();
    rst_n  = 1'b1;
  endtask

  // Lines of 100 clocks (hsync on c0..c9), vsync on line 0 at c=vs_off for 10 clocks,
  // pixel 0x3F on c>=60 when lit. Line nlines-2 lasts last_len clocks; line nlines-1 stops at last_c.
  task automatic gen(input int nlines, input int last_c, input int vs_off, input int last_len,
                     input bit lit, input bit pol, input bit wr_end);
    for (int l = 0; l < nlines; l++) begin
      int len;
      len = (l == nlines - 2) ? last_len : 100;
      if (l == nlines - 1) len = last_c + 1;
      for (int c = 0; c < len; c++) begin
        bit hs;
        bit vs;
        logic [5:0] px;
        hs = (c < 10);
        vs = ((l % 10) == 0) && (c >= vs_off) && (c < vs_off + 10);
        px = (lit && c >= 60) ? 6'h3F : 6'h00;
        vga_in = {(pol ? vs : ~vs), (pol ? hs : ~hs), px};
        if (wr_end && (l == nlines - 1) && (c == len - 1)) begin
          address      = 6'h04;
          data_in      = 32'h0;
          data_write_n = 2'b10;
        end
        tick();
        data_write_n = 2'b11;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [5:0]  a [9];
    a = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10, 6'h14, 6'h18, 6'h1C, 6'h3C};
    do_reset(1'b1);
    for (int i = 0; i < 9; i++) begin
      rd(a[i], d);
      n_checks++;
      if (d !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_read[0x%0h]: got 0x%0h, expected 0x0", a[i], d);
      end
    end
    n_checks++;
    if (user_interrupt !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_irq: got %b, expected 0", user_interrupt);
    end
    n_checks++;
    if (data_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b, expected 1", data_ready);
    end
  endtask

  task automatic test_frame_basic();
    logic [31:0] d;
    logic [5:0]  a [6];
    logic [31:0] e [6];
    a = '{6'h08, 6'h0C, 6'h10, 6'h14, 6'h18, 6'h04};
    e = '{32'd100, 32'd10, 32'd0, 32'd0, 32'd1, 32'h1};
    wr(6'h00, 32'h0000_0003, 2'b00);
    idle(5, 1'b1);
    gen(11, 50, 50, 100, 1'b0, 1'b1, 1'b0);
    idle(3, 1'b1);
    for (int i = 0; i < 6; i++) begin
      rd(a[i], d);
      n_checks++;
      if (d !== e[i]) begin
        n_fail++;
        $display("FAIL basic_reg[0x%0h]: got 0x%0h, expected 0x%0h", a[i], d, e[i]);
      end
    end
    n_checks++;
    if (user_interrupt !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_irq_masked: got %b, expected 0", user_interrupt);
    end
  endtask

  task automatic test_lit();
    logic [31:0] d;
    logic [5:0]  a [6];
    logic [31:0] e [6];
    a = '{6'h00, 6'h08, 6'h0C, 6'h10, 6'h14, 6'h18};
    e = '{32'h3, 32'd100, 32'd10, 32'd400, 32'h0000_6270, 32'd2};
    wr(6'h00, 32'h0000_0000, 2'b01);
    idle(2, 1'b1);
    wr(6'h00, 32'hFFFF_FF03, 2'b10);
    idle(5, 1'b1);
    gen(11, 50, 50, 100, 1'b1, 1'b1, 1'b0);
    idle(3, 1'b1);
    for (int i = 0; i < 6; i++) begin
      rd(a[i], d);
      n_checks++;
      if (d !== e[i]) begin
        n_fail++;
        $display("FAIL lit_reg[0x%0h]: got 0x%0h, expected 0x%0h", a[i], d, e[i]);
      end
    end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    wr(6'h04, 32'h0, 2'b10);
    wr(6'h00, 32'h0, 2'b00);
    idle(2, 1'b1);
    wr(6'h00, 32'h7, 2'b00);
    n_checks++;
    if (user_interrupt !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_before_frame: got %b, expected 0", user_interrupt);
    end
    idle(5, 1'b1);
    gen(11, 50, 50, 100, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1);
    n_checks++;
    if (user_interrupt !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_after_frame: got %b, expected 1", user_interrupt);
    end
    wr(6'h04, 32'h0, 2'b00);
    n_checks++;
    if (user_interrupt !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_cleared: got %b, expected 0", user_interrupt);
    end
    wr(6'h00, 32'h0, 2'b00);
    idle(2, 1'b1);
    wr(6'h00, 32'h7, 2'b00);
    idle(5, 1'b1);
    gen(11, 50, 50, 100, 1'b0, 1'b1, 1'b1);
    idle(2, 1'b1);
    rd(6'h04, d);
    n_checks++;
    if (d !== 32'h1) begin
      n_fail++;
      $display("FAIL irq_set_wins: status got 0x%0h, expected 0x1", d);
    end
    rd(6'h18, d);
    n_checks++;
    if (d !== 32'd4) begin
      n_fail++;
      $display("FAIL irq_frames: got %0d, expected 4", d);
    end
    n_checks++;
    if (user_interrupt !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_after_set_wins: got %b, expected 1", user_interrupt);
    end
  endtask

  task automatic test_coincident(input bit pol);
    logic [31:0] d;
    logic [5:0]  a [6];
    logic [31:0] e [6];
    a = '{6'h08, 6'h0C, 6'h10, 6'h14, 6'h18, 6'h04};
    e = '{32'd77, 32'd10, 32'd377, 32'd23751, 32'd1, 32'h1};
    do_reset(pol);
    wr(6'h00, {30'd0, pol, 1'b1}, 2'b00);
    idle(5, pol);
    gen(11, 0, 0, 77, 1'b1, pol, 1'b0);
    for (int i = 0; i < 6; i++) begin
      rd(a[i], d);
      n_checks++;
      if (d !== e[i]) begin
        n_fail++;
        $display("FAIL coincident_pol%0d_reg[0x%0h]: got 0x%0h, expected 0x%0h", pol, a[i], d, e[i]);
      end
    end
    tick();
    idle(18, pol);
    hpulse(pol);
    idle(2, pol);
    rd(6'h08, d);
    n_checks++;
    if (d !== 32'd20) begin
      n_fail++;
      $display("FAIL coincident_pol%0d_restart: htotal got %0d, expected 20", pol, d);
    end
  endtask

  task automatic test_saturation_disable();
    logic [31:0] d;
    logic [5:0]  a [4];
    logic [31:0] e [4];
    a = '{6'h0C, 6'h10, 6'h14, 6'h18};
    e = '{32'd10, 32'd377, 32'd23751, 32'd1};
    idle(70000, 1'b0);
    rd(6'h04, d);
    n_checks++;
    if (d !== 32'h3) begin
      n_fail++;
      $display("FAIL sat_status: got 0x%0h, expected 0x3", d);
    end
    hpulse(1'b0);
    idle(2, 1'b0);
    rd(6'h08, d);
    n_checks++;
    if (d !== 32'h0000_FFFF) begin
      n_fail++;
      $display("FAIL sat_htotal: got 0x%0h, expected 0xffff", d);
    end
    wr(6'h00, 32'h0, 2'b00);
    idle(3, 1'b0);
    vpulse(1'b0);
    idle(3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      rd(a[i], d);
      n_checks++;
      if (d !== e[i]) begin
        n_fail++;
        $display("FAIL disable_hold[0x%0h]: got 0x%0h, expected 0x%0h", a[i], d, e[i]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d;
    do_reset(1'b1);
    wr(6'h00, 32'h3, 2'b00);
    idle(5, 1'b1);
    gen(6, 99, 50, 100, 1'b1, 1'b1, 1'b0);
    do_reset(1'b1);
    rd(6'h10, d);
    n_checks++;
    if (d !== 32'd0) begin
      n_fail++;
      $display("FAIL midreset_lit: got %0d, expected 0", d);
    end
    wr(6'h00, 32'h3, 2'b00);
    idle(5, 1'b1);
    gen(11, 50, 50, 100, 1'b1, 1'b1, 1'b0);
    idle(2, 1'b1);
    rd(6'h10, d);
    n_checks++;
    if (d !== 32'd400) begin
      n_fail++;
      $display("FAIL midreset_lit_after: got %0d, expected 400", d);
    end
    rd(6'h18, d);
    n_checks++;
    if (d !== 32'd1) begin
      n_fail++;
      $display("FAIL midreset_frames: got %0d, expected 1", d);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    vga_in       = 8'h00;
    address      = 6'h00;
    data_in      = 32'h0;
    data_write_n = 2'b11;
    data_read_n  = 2'b11;
    test_reset();
    test_frame_basic();
    test_lit();
    test_irq();
    test_coincident(1'b1);
    test_coincident(1'b0);
    test_saturation_disable();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
